// File: rtl/pe_types.sv
// Shared PE-mesh types plus a reusable round-robin picker.
package pe_types;

  localparam int unsigned PKT_SRC_W  = 4;
  localparam int unsigned PKT_DST_W  = 4;
  localparam int unsigned PKT_DATA_W = 24;

  typedef struct packed {
    logic [PKT_SRC_W-1:0]  src;
    logic [PKT_DST_W-1:0]  dst;
    logic [PKT_DATA_W-1:0] payload;
  } packet_t;

  localparam int MESH_DRAIN_CH = 8;

  // Widest request vector rr_pick handles; callers zero-extend narrower ones.
  localparam int unsigned RR_MAX_W = 32;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX_W);

  // One-hot grant to the first requester at or after ptr, wrapping at n.
  function automatic logic [RR_MAX_W-1:0] rr_pick(
    input logic [RR_MAX_W-1:0] req,
    input int unsigned         ptr,
    input int unsigned         n = MESH_DRAIN_CH
  );
    logic [RR_MAX_W-1:0] gnt;
    logic                found;
    int unsigned         idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_W; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[RR_IDX_W'(idx)]) begin
        gnt[RR_IDX_W'(idx)] = 1'b1;
        found               = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pe_drain_fifo.sv
// First-word-fall-through circular buffer; head is read straight from storage.
module pe_drain_fifo
  import pe_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  packet_t                      push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output packet_t                      rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  packet_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_mesh_drain.sv
// Round-robin merge of the mesh output channels into one pull-handshake stream.
module pe_mesh_drain
  import pe_types::*;
#(
  parameter int unsigned N_CH  = MESH_DRAIN_CH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [N_CH-1:0]      mesh_out_deq,
  input  logic [N_CH-1:0]      mesh_out_empty,
  input  packet_t [N_CH-1:0]   mesh_out_rdata,
  input  logic                 drain_en,
  input  logic                 out_deq,
  output logic                 out_empty,
  output packet_t              out_rdata,
  output logic                 idle,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int unsigned PTR_W = $clog2(N_CH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_ptr_nxt;
  logic [PTR_W-1:0]    gidx;
  logic [N_CH-1:0]     grant;
  logic [RR_MAX_W-1:0] pick;
  logic                space;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic [CW-1:0]       fifo_count;
  packet_t             push_data;

  // Grant selection; out_deq only matters when the buffer is full.
  always_comb begin
    grant      = '0;
    gidx       = '0;
    push_data  = '0;
    rr_ptr_nxt = rr_ptr;
    space      = !fifo_full || out_deq;
    pick       = rr_pick(RR_MAX_W'(~mesh_out_empty), 32'(rr_ptr), N_CH);
    if (rst && drain_en && space) grant = N_CH'(pick);
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gidx      = PTR_W'(i);
        push_data = mesh_out_rdata[i];
      end
    end
    push = |grant;
    if (push) rr_ptr_nxt = (32'(gidx) == N_CH - 1) ? '0 : gidx + PTR_W'(1);
  end

  assign mesh_out_deq = grant;
  assign pop          = out_deq && (fifo_count != '0);
  assign idle         = out_empty && (&mesh_out_empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (pop && (pkt_count != {CNT_W{1'b1}})) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  pe_drain_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_deq),
    .full      (fifo_full),
    .empty     (out_empty),
    .count     (fifo_count),
    .rdata     (out_rdata)
  );

endmodule

// File: tb/tb_pe_mesh_drain.sv
// Randomized bench for pe_mesh_drain against a queue-based reference model.
module tb_pe_mesh_drain;
  import pe_types::*;

  localparam int unsigned N = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    mesh_out_deq, sat_deq, mesh_out_empty;
  packet_t [N-1:0] mesh_out_rdata;
  logic            drain_en, out_deq;
  logic            out_empty, idle, sat_empty, sat_idle;
  packet_t         out_rdata, sat_rdata;
  logic [15:0]     pkt_count;
  logic [3:0]      sat_count;

  pe_mesh_drain #(.N_CH(N), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mesh_out_deq(mesh_out_deq), .mesh_out_empty(mesh_out_empty),
    .mesh_out_rdata(mesh_out_rdata), .drain_en(drain_en), .out_deq(out_deq),
    .out_empty(out_empty), .out_rdata(out_rdata), .idle(idle), .pkt_count(pkt_count)
  );

  pe_mesh_drain #(.N_CH(N), .DEPTH(D), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .mesh_out_deq(sat_deq), .mesh_out_empty(mesh_out_empty),
    .mesh_out_rdata(mesh_out_rdata), .drain_en(drain_en), .out_deq(out_deq),
    .out_empty(sat_empty), .out_rdata(sat_rdata), .idle(sat_idle), .pkt_count(sat_count)
  );

  int total = 0;
  int bad   = 0;

  packet_t      chq [N][$];
  packet_t      rq [$];
  int           ref_ptr, ref_cnt, ref_sat, grants_seen;
  logic [N-1:0] exp_grant;

  function automatic packet_t mk_pkt(int ch);
    packet_t p;
    p.src     = 4'(ch);
    p.dst     = 4'($urandom);
    p.payload = 24'($urandom);
    return p;
  endfunction

  function automatic bit any_chan();
    for (int i = 0; i < N; i++) if (chq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // First non-empty channel at or after the pointer, if the buffer can take it.
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g = '0;
    if (rst !== 1'b1 || !drain_en) return g;
    if (!(rq.size() < D || (rq.size() == D && out_deq))) return g;
    for (int k = 0; k < N; k++) begin
      int idx = (ref_ptr + k) % N;
      if (chq[idx].size() > 0) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic drive_channels();
    for (int i = 0; i < N; i++) begin
      mesh_out_empty[i] = (chq[i].size() == 0);
      mesh_out_rdata[i] = (chq[i].size() == 0) ? mk_pkt(15) : chq[i][0];
    end
  endtask

  task automatic clear_chans();
    for (int i = 0; i < N; i++) chq[i].delete();
  endtask

  // One clock: check registered outputs, drive, check grants, advance the model.
  task automatic cycle();
    bit exp_empty, exp_idle;
    exp_empty = (rq.size() == 0);
    total++;
    if (out_empty !== exp_empty) begin
      bad++; $display("FAIL out_empty got=%b exp=%b t=%0t", out_empty, exp_empty, $time);
    end
    if (rq.size() > 0) begin
      total++;
      if (out_rdata !== rq[0]) begin
        bad++; $display("FAIL out_rdata got=%h exp=%h t=%0t", out_rdata, rq[0], $time);
      end
    end
    total++;
    if (pkt_count !== 16'(ref_cnt)) begin
      bad++; $display("FAIL pkt_count got=%0d exp=%0d t=%0t", pkt_count, ref_cnt, $time);
    end
    total++;
    if (sat_count !== 4'(ref_sat)) begin
      bad++; $display("FAIL sat_count got=%0d exp=%0d t=%0t", sat_count, ref_sat, $time);
    end
    drive_channels();
    #1;
    exp_grant = model_grant();
    exp_idle  = (rq.size() == 0) && !any_chan();
    total++;
    if (mesh_out_deq !== exp_grant) begin
      bad++; $display("FAIL grant got=%b exp=%b t=%0t", mesh_out_deq, exp_grant, $time);
    end
    total++;
    if (sat_deq !== exp_grant) begin
      bad++; $display("FAIL sat_grant got=%b exp=%b t=%0t", sat_deq, exp_grant, $time);
    end
    total++;
    if (idle !== exp_idle) begin
      bad++; $display("FAIL idle got=%b exp=%b t=%0t", idle, exp_idle, $time);
    end
    grants_seen += $countones(mesh_out_deq);
    @(posedge clk);
    if (out_deq && rq.size() > 0) begin
      void'(rq.pop_front());
      ref_cnt++;
      if (ref_sat < 15) ref_sat++;
    end
    for (int i = 0; i < N; i++) begin
      if (exp_grant[i]) begin
        rq.push_back(chq[i].pop_front());
        ref_ptr = (i + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rq.delete();
    ref_ptr = 0; ref_cnt = 0; ref_sat = 0;
    drive_channels();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain_all();
    out_deq = 1'b1; drain_en = 1'b1;
    for (int i = 0; i < 200 && (rq.size() > 0 || any_chan()); i++) cycle();
    total++;
    if (rq.size() > 0 || any_chan()) begin
      bad++; $display("FAIL drain_timeout got=%0d exp=0", rq.size());
    end
  endtask

  task automatic test_reset();
    clear_chans();
    chq[0].push_back(mk_pkt(0));
    chq[3].push_back(mk_pkt(3));
    drive_channels();
    rst = 1'b0; drain_en = 1'b1; out_deq = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if (mesh_out_deq !== '0 || out_empty !== 1'b1 || pkt_count !== 16'd0 || idle !== 1'b0) begin
        bad++; $display("FAIL reset_state got=%b/%b/%0d/%b exp=0/1/0/0",
                        mesh_out_deq, out_empty, pkt_count, idle);
      end
      total++;
      if (out_rdata !== '0) begin
        bad++; $display("FAIL reset_rdata got=%h exp=0", out_rdata);
      end
    end
    @(negedge clk);
    do_reset();
    drain_all();
  endtask

  task automatic test_single();
    packet_t p;
    clear_chans(); do_reset();
    out_deq = 1'b0; drain_en = 1'b1;
    p = mk_pkt(5);
    chq[5].push_back(p);
    cycle();
    cycle();
    total++;
    if (out_empty !== 1'b0 || out_rdata !== p) begin
      bad++; $display("FAIL single_pkt got=%b/%h exp=0/%h", out_empty, out_rdata, p);
    end
    // Pointer now 6: channel 7 must win over channel 4.
    chq[4].push_back(mk_pkt(4));
    chq[7].push_back(mk_pkt(7));
    cycle();
    cycle();
    drain_all();
  endtask

  task automatic test_all_loaded();
    clear_chans();
    for (int i = 0; i < N; i++) repeat (3) chq[i].push_back(mk_pkt(i));
    do_reset();
    out_deq = 1'b1; drain_en = 1'b1;
    repeat (17) cycle();
    total++;
    if (pkt_count !== 16'd16) begin
      bad++; $display("FAIL count_16 got=%0d exp=16", pkt_count);
    end
    repeat (10) cycle();
    total++;
    if (pkt_count !== 16'd24) begin
      bad++; $display("FAIL count_24 got=%0d exp=24", pkt_count);
    end
    total++;
    if (sat_count !== 4'd15) begin
      bad++; $display("FAIL saturate got=%0d exp=15", sat_count);
    end
  endtask

  task automatic test_backpressure();
    clear_chans(); do_reset();
    out_deq = 1'b0; drain_en = 1'b1;
    repeat (6) begin chq[2].push_back(mk_pkt(2)); chq[3].push_back(mk_pkt(3)); end
    grants_seen = 0;
    repeat (8) cycle();
    total++;
    if (grants_seen !== 4) begin
      bad++; $display("FAIL bp_fill got=%0d exp=4", grants_seen);
    end
    out_deq = 1'b1; grants_seen = 0;
    cycle();
    total++;
    if (grants_seen !== 1) begin
      bad++; $display("FAIL bp_popgrant got=%0d exp=1", grants_seen);
    end
    out_deq = 1'b0; grants_seen = 0;
    repeat (2) cycle();
    total++;
    if (grants_seen !== 0) begin
      bad++; $display("FAIL bp_refull got=%0d exp=0", grants_seen);
    end
    drain_all();
  endtask

  task automatic test_empty_pop_drain();
    int cnt_before;
    clear_chans(); drain_all();
    cnt_before = ref_cnt;
    out_deq = 1'b1;
    repeat (3) cycle();
    total++;
    if (pkt_count !== 16'(cnt_before)) begin
      bad++; $display("FAIL empty_pop got=%0d exp=%0d", pkt_count, cnt_before);
    end
    out_deq = 1'b0;
    foreach (chq[i]) if (i == 1 || i == 4 || i == 6) repeat (2) chq[i].push_back(mk_pkt(i));
    repeat (3) cycle();
    drain_en = 1'b0; out_deq = 1'b1;
    repeat (4) cycle();
    total++;
    if (out_empty !== 1'b1 || idle !== 1'b0) begin
      bad++; $display("FAIL drain_off got=%b/%b exp=1/0", out_empty, idle);
    end
    clear_chans();
    drive_channels(); #1;
    total++;
    if (idle !== 1'b1) begin
      bad++; $display("FAIL idle_high got=%b exp=1", idle);
    end
    @(negedge clk);
    drain_en = 1'b1;
  endtask

  task automatic test_async_reset();
    clear_chans(); do_reset();
    for (int i = 0; i < N; i++) repeat (3) chq[i].push_back(mk_pkt(i));
    drain_en = 1'b1; out_deq = 1'b1;
    repeat (4) cycle();
    out_deq = 1'b0;
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1;
    total++;
    if (out_empty !== 1'b1 || pkt_count !== 16'd0 || mesh_out_deq !== '0) begin
      bad++; $display("FAIL async_rst got=%b/%0d/%b exp=1/0/0", out_empty, pkt_count, mesh_out_deq);
    end
    rq.delete(); ref_ptr = 0; ref_cnt = 0; ref_sat = 0;
    @(negedge clk); #1;
    total++;
    if (mesh_out_deq !== '0) begin
      bad++; $display("FAIL rst_deq got=%b exp=0", mesh_out_deq);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    drain_all();
  endtask

  task automatic test_random();
    clear_chans(); do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (chq[i].size() < 4 && $urandom_range(9) < 3) chq[i].push_back(mk_pkt(i));
      out_deq  = ($urandom_range(2) != 0);
      drain_en = ($urandom_range(7) != 0);
      cycle();
    end
    drain_all();
  endtask

  initial begin
    rst = 1'b0; drain_en = 1'b1; out_deq = 1'b0;
    ref_ptr = 0; ref_cnt = 0; ref_sat = 0; grants_seen = 0;
    clear_chans();
    drive_channels();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_loaded();
    test_backpressure();
    test_empty_pop_drain();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
